crop_normalizer: RTL and testbench

Downstream consumer of the crop filter's output FIFO. Buffers one cropped OUT_ROWS×OUT_COLS frame in on-chip RAM while tracking its maximum pixel value. It then replays the frame, left-shifting every pixel by the count of leading zeros of that maximum, so the brightest pixel's MSB lands at bit PIXEL_BIT_WIDTH-1. Output is an AXI-Stream of normalized pixels for the inference/packing stage.

---
 rtl/crop_pkg.sv | 38 +++
 rtl/norm_frame_ram.sv | 29 ++
 rtl/crop_normalizer.sv | 219 +++++++++++++++++++++
 tb/tb_crop_normalizer.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/crop_pkg.sv
// Shared state type and width/leading-zero helpers for the crop normalizer.
// Latency: none; types and pure functions only.
// Backpressure: not applicable.
package crop_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    CALC  = 2'd2,
    DRAIN = 2'd3
  } crop_norm_state_t;

  // Address bits needed to index a frame of 'depth' pixels (at least one bit).
  function automatic int addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Bits needed to hold a shift amount in the range 0..pw.
  function automatic int shift_width(input int pw);
    return $clog2(pw + 1);
  endfunction

  // Leading zeros of the low 'width' bits of 'value'; returns width for zero.
  function automatic int clz(input logic [31:0] value, input int width);
    int   n;
    logic seen;
    n    = 0;
    seen = 1'b0;
    for (int i = 31; i >= 0; i--) begin
      if (i < width) begin
        if (value[i]) seen = 1'b1;
        else if (!seen) n++;
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/norm_frame_ram.sv
// Simple dual-port frame store: one write port, one registered read port.
// Latency: read data appears one cycle after rd_en.
// Backpressure: none; read data holds while rd_en is low.
module norm_frame_ram #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 12,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_dat,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_dat
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rd_dat_q;

  // Synchronous write and registered read, no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_dat;
    if (rd_en) rd_dat_q <= mem[rd_addr];
  end

  assign rd_dat = rd_dat_q;

endmodule

// File: rtl/crop_normalizer.sv
// Captures one cropped frame, then replays it left-shifted so the frame max fills the MSB.
// Latency: first output beat 3 cycles after the last input beat; N beats in N+2 cycles.
// Backpressure: RAM reads throttled by a 2-entry output/skid stage; optional CROP_NORM_STATS_EN adds frame_max/frame_shift.
module crop_normalizer
  import crop_pkg::*;
#(
  parameter int PIXEL_BIT_WIDTH = 10,
  parameter int USER_WIDTH      = 2,
  parameter int OUT_ROWS        = 10,
  parameter int OUT_COLS        = 10
) (
  input  logic                       clk,
  input  logic                       s_axis_resetn,
  input  logic                       ap_start,
  output logic                       ap_done,
  input  logic                       s_axis_tvalid,
  output logic                       s_axis_tready,
  input  logic [PIXEL_BIT_WIDTH-1:0] s_axis_tdata,
  input  logic [USER_WIDTH-1:0]      s_axis_tuser,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready,
  output logic [PIXEL_BIT_WIDTH-1:0] m_axis_tdata,
  output logic [USER_WIDTH-1:0]      m_axis_tuser,
  output logic                       m_axis_tlast
`ifdef CROP_NORM_STATS_EN
  , output logic [PIXEL_BIT_WIDTH-1:0]           frame_max
  , output logic [$clog2(PIXEL_BIT_WIDTH+1)-1:0] frame_shift
`endif
);

  localparam int PW = PIXEL_BIT_WIDTH;
  localparam int UW = USER_WIDTH;
  localparam int N  = OUT_ROWS * OUT_COLS;
  localparam int AW = addr_width(N);
  localparam int SW = shift_width(PW);
  localparam int RW = PW + UW;

  typedef struct packed {
    logic          last;
    logic [UW-1:0] user;
    logic [PW-1:0] data;
  } beat_t;

  crop_norm_state_t state_q, state_d;
  logic [AW-1:0]    wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d;
  logic             rd_all_q, rd_all_d;
  logic [PW-1:0]    max_q, max_d;
  logic [SW-1:0]    shift_q, shift_d;
  logic             s_rdy_q, s_rdy_d, ap_done_q, ap_done_d;
  logic             ram_vld_q, ram_vld_d, ram_last_q, ram_last_d;
  logic             out_vld_q, out_vld_d, skid_vld_q, skid_vld_d;
  beat_t            out_q, out_d, skid_q, skid_d, ram_beat;
`ifdef CROP_NORM_STATS_EN
  logic [PW-1:0]    frame_max_q, frame_max_d;
  logic [SW-1:0]    frame_shift_q, frame_shift_d;
`endif

  logic             s_hs, pop, rd_en;
  logic [2:0]       occ_next;
  logic [RW-1:0]    ram_rdat;

  assign s_hs = s_axis_tvalid & s_rdy_q;
  assign pop  = out_vld_q & m_axis_tready;
  // Entries held by output+skid after this edge; a read is only issued if its data will find room.
  assign occ_next = {2'b00, out_vld_q} + {2'b00, skid_vld_q} + {2'b00, ram_vld_q} - {2'b00, pop};
  assign rd_en    = (state_q == DRAIN) && !rd_all_q && (occ_next <= 3'd1);

  norm_frame_ram #(.DEPTH(N), .WIDTH(RW), .AW(AW)) u_ram (
    .clk     (clk),
    .wr_en   (s_hs),
    .wr_addr (wr_addr_q),
    .wr_dat  ({s_axis_tuser, s_axis_tdata}),
    .rd_en   (rd_en),
    .rd_addr (rd_addr_q),
    .rd_dat  (ram_rdat)
  );

  // Normalize the pixel as it leaves the RAM so the output stage holds final values.
  always_comb begin
    ram_beat.data = ram_rdat[PW-1:0] << shift_q;
    ram_beat.user = ram_rdat[RW-1:PW];
    ram_beat.last = ram_last_q;
  end

  // Next-state logic: FSM, max tracking, read sequencing and the output/skid pair.
  always_comb begin
    state_d    = state_q;
    wr_addr_d  = wr_addr_q;
    rd_addr_d  = rd_addr_q;
    rd_all_d   = rd_all_q;
    max_d      = max_q;
    shift_d    = shift_q;
    s_rdy_d    = s_rdy_q;
    ap_done_d  = 1'b0;
    ram_vld_d  = rd_en;
    ram_last_d = rd_en && (rd_addr_q == AW'(N-1));
    out_vld_d  = out_vld_q;
    out_d      = out_q;
    skid_vld_d = skid_vld_q;
    skid_d     = skid_q;
`ifdef CROP_NORM_STATS_EN
    frame_max_d   = frame_max_q;
    frame_shift_d = frame_shift_q;
`endif

    case (state_q)
      IDLE: begin
        if (ap_start) begin
          state_d   = FILL;
          wr_addr_d = '0;
          max_d     = '0;
          s_rdy_d   = 1'b1;
        end
      end
      FILL: begin
        if (s_hs) begin
          wr_addr_d = wr_addr_q + 1'b1;
          if (s_axis_tdata > max_q) max_d = s_axis_tdata;
          if (wr_addr_q == AW'(N-1)) begin
            state_d = CALC;
            s_rdy_d = 1'b0;
          end
        end
      end
      CALC: begin
        shift_d   = (max_q == '0) ? '0 : SW'(clz(32'(max_q), PW));
        rd_addr_d = '0;
        rd_all_d  = 1'b0;
        state_d   = DRAIN;
`ifdef CROP_NORM_STATS_EN
        frame_max_d   = max_q;
        frame_shift_d = (max_q == '0) ? '0 : SW'(clz(32'(max_q), PW));
`endif
      end
      DRAIN: begin
        if (rd_en) begin
          rd_addr_d = rd_addr_q + 1'b1;
          if (rd_addr_q == AW'(N-1)) rd_all_d = 1'b1;
        end
        if (pop && out_q.last) begin
          state_d   = IDLE;
          ap_done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Output stage is the head, skid the second slot; a stalled head never changes.
    if (pop) begin
      out_vld_d  = skid_vld_q;
      out_d      = skid_q;
      skid_vld_d = 1'b0;
    end
    if (ram_vld_q) begin
      if (!out_vld_d) begin
        out_vld_d = 1'b1;
        out_d     = ram_beat;
      end else begin
        skid_vld_d = 1'b1;
        skid_d     = ram_beat;
      end
    end
  end

  // State registers with asynchronous frame abort.
  always_ff @(posedge clk or negedge s_axis_resetn) begin
    if (!s_axis_resetn) begin
      state_q    <= IDLE;
      wr_addr_q  <= '0;
      rd_addr_q  <= '0;
      rd_all_q   <= 1'b0;
      max_q      <= '0;
      shift_q    <= '0;
      s_rdy_q    <= 1'b0;
      ap_done_q  <= 1'b0;
      ram_vld_q  <= 1'b0;
      ram_last_q <= 1'b0;
      out_vld_q  <= 1'b0;
      out_q      <= '0;
      skid_vld_q <= 1'b0;
      skid_q     <= '0;
`ifdef CROP_NORM_STATS_EN
      frame_max_q   <= '0;
      frame_shift_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      wr_addr_q  <= wr_addr_d;
      rd_addr_q  <= rd_addr_d;
      rd_all_q   <= rd_all_d;
      max_q      <= max_d;
      shift_q    <= shift_d;
      s_rdy_q    <= s_rdy_d;
      ap_done_q  <= ap_done_d;
      ram_vld_q  <= ram_vld_d;
      ram_last_q <= ram_last_d;
      out_vld_q  <= out_vld_d;
      out_q      <= out_d;
      skid_vld_q <= skid_vld_d;
      skid_q     <= skid_d;
`ifdef CROP_NORM_STATS_EN
      frame_max_q   <= frame_max_d;
      frame_shift_q <= frame_shift_d;
`endif
    end
  end

  assign s_axis_tready = s_rdy_q;
  assign ap_done       = ap_done_q;
  assign m_axis_tvalid = out_vld_q;
  assign m_axis_tdata  = out_q.data;
  assign m_axis_tuser  = out_q.user;
  assign m_axis_tlast  = out_q.last;
`ifdef CROP_NORM_STATS_EN
  assign frame_max     = frame_max_q;
  assign frame_shift   = frame_shift_q;
`endif

endmodule

// File: tb/tb_crop_normalizer.sv
// Bench for crop_normalizer: directed and random frames against a reference model.
// Latency: checks first-beat latency and N-beats-in-N+2-cycles throughput.
// Backpressure: exercises toggled and random m_axis_tready with stall-stability checks.
module tb_crop_normalizer;

  localparam int PW = 10;
  localparam int UW = 2;
  localparam int R  = 4;
  localparam int C  = 4;
  localparam int N  = R * C;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ap_start = 1'b0;
  logic          ap_done;
  logic          s_tvalid = 1'b0;
  logic          s_tready;
  logic [PW-1:0] s_tdata = '0;
  logic [UW-1:0] s_tuser = '0;
  logic          m_tvalid;
  logic          m_tready = 1'b0;
  logic [PW-1:0] m_tdata;
  logic [UW-1:0] m_tuser;
  logic          m_tlast;
`ifdef CROP_NORM_STATS_EN
  logic [PW-1:0]              frame_max;
  logic [$clog2(PW+1)-1:0]    frame_shift;
`endif

  crop_normalizer #(
    .PIXEL_BIT_WIDTH (PW),
    .USER_WIDTH      (UW),
    .OUT_ROWS        (R),
    .OUT_COLS        (C)
  ) dut (
    .clk           (clk),
    .s_axis_resetn (rst_n),
    .ap_start      (ap_start),
    .ap_done       (ap_done),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .s_axis_tdata  (s_tdata),
    .s_axis_tuser  (s_tuser),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tuser  (m_tuser),
    .m_axis_tlast  (m_tlast)
`ifdef CROP_NORM_STATS_EN
    , .frame_max   (frame_max)
    , .frame_shift (frame_shift)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int pix[N];
  int usr[N];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: smallest shift that puts the max's top set bit at the MSB.
  function automatic int model_shift(input int mx);
    int s;
    s = 0;
    if (mx == 0) return 0;
    while ((mx << s) < (1 << (PW - 1))) s++;
    return s;
  endfunction

  task automatic start_frame();
    ap_start = 1'b1;
    tick();
    ap_start = 1'b0;
    chk("start_fill_rdy", s_tready, 1);
  endtask

  task automatic fill(input int pulse_at, input bit gaps, input bit keep_vld);
    int  i;
    int  cyc;
    bit  hs;
    i = 0;
    cyc = 0;
    while (i < N && cyc < 200) begin
      s_tvalid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      s_tdata  = PW'(pix[i]);
      s_tuser  = UW'(usr[i]);
      ap_start = (i == pulse_at);
      hs = s_tvalid && s_tready;
      tick();
      cyc++;
      if (hs) i++;
    end
    ap_start = 1'b0;
    s_tvalid = keep_vld;
    s_tdata  = '1;
    chk("fill_count", i, N);
    chk("srdy_after_last", s_tready, 0);
  endtask

  // mode 0: ready high, 1: toggling, 2: random. abort_after > N means run to completion.
  task automatic drain(input int mode, input int abort_after, input bit restart, input bit timing);
    int          mx, sh, k, cyc, first;
    bit          stalled, rdy;
    logic [31:0] held;
    mx = 0;
    for (int i = 0; i < N; i++) if (pix[i] > mx) mx = pix[i];
    sh = model_shift(mx);
    k = 0; cyc = 0; first = -1; stalled = 0; held = '0;
    while (k < N && cyc < 400 && k != abort_after) begin
      if (m_tvalid && first < 0) first = cyc;
      if (stalled) chk("stall_hold", {m_tvalid, m_tdata, m_tuser, m_tlast}, held);
      if (cyc == 1) chk("drain_srdy", s_tready, 0);
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 2 == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      m_tready = rdy;
      if (m_tvalid && rdy) begin
        chk("tdata", m_tdata, (pix[k] << sh) & ((1 << PW) - 1));
        chk("tuser", m_tuser, usr[k]);
        chk("tlast", m_tlast, (k == N - 1));
        k++;
        stalled = 0;
      end else if (m_tvalid) begin
        stalled = 1;
        held = {18'd0, 1'b1, m_tdata, m_tuser, m_tlast};
      end else begin
        stalled = 0;
      end
      tick();
      cyc++;
    end
    m_tready = 1'b0;
    if (abort_after <= N) begin
      chk("abort_beats", k, abort_after);
    end else begin
      chk("beat_count", k, N);
      chk("done_pulse", ap_done, 1);
      if (timing) begin
        chk("first_valid_cycle", first, 3);
        chk("drain_cycles", cyc, N + 3);
      end
      ap_start = restart;
      tick();
      ap_start = 1'b0;
      chk("done_clear", ap_done, 0);
      if (restart) chk("restart_fill_rdy", s_tready, 1);
    end
  endtask

  initial begin
    #2;
    chk("rst_tvalid", m_tvalid, 0);
    chk("rst_tready", s_tready, 0);
    chk("rst_tlast", m_tlast, 0);
    chk("rst_done", ap_done, 0);
    chk("rst_tdata", m_tdata, 0);
    chk("rst_tuser", m_tuser, 0);
    tick(); tick();
    #2 rst_n = 1'b1;
    tick();

    // 1: ramp, tuser 01, full-rate drain with latency/throughput checks.
    for (int i = 0; i < N; i++) begin pix[i] = i; usr[i] = 1; end
    start_frame();
    fill(-1, 0, 0);
    drain(0, N + 1, 0, 1);

    // 2: all-zero frame; ap_start in the ap_done cycle starts the next fill.
    for (int i = 0; i < N; i++) begin pix[i] = 0; usr[i] = i % 4; end
    start_frame();
    fill(-1, 0, 0);
    drain(0, N + 1, 1, 1);

    // 3: full-scale pixel among small values passes through unchanged.
    for (int i = 0; i < N; i++) begin pix[i] = $urandom_range(0, 100); usr[i] = $urandom_range(0, 3); end
    pix[9] = 1023;
    fill(-1, 0, 0);
    drain(0, N + 1, 0, 1);

    // 4: lone pixel 5 at index 7, drained at full rate then with toggled ready.
    for (int i = 0; i < N; i++) begin pix[i] = 0; usr[i] = 2; end
    pix[7] = 5;
    start_frame();
    fill(-1, 0, 0);
    drain(0, N + 1, 0, 1);
    start_frame();
    fill(-1, 0, 0);
    drain(1, N + 1, 0, 0);

    // 5: reset after 5 drain beats aborts the frame; a fresh ramp still works.
    for (int i = 0; i < N; i++) begin pix[i] = i; usr[i] = 1; end
    start_frame();
    fill(-1, 0, 0);
    drain(0, 5, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_tvalid", m_tvalid, 0);
    chk("abort_tready", s_tready, 0);
    for (int c = 0; c < 3; c++) begin
      chk("abort_no_done", ap_done, 0);
      tick();
    end
    #2 rst_n = 1'b1;
    tick();
    chk("post_reset_done", ap_done, 0);
    start_frame();
    fill(-1, 0, 0);
    drain(0, N + 1, 0, 1);

    // 6: beats offered in IDLE are refused; ap_start mid-FILL is ignored.
    for (int i = 0; i < N; i++) begin pix[i] = $urandom_range(0, 300); usr[i] = $urandom_range(0, 3); end
    s_tvalid = 1'b1;
    s_tdata  = '1;
    for (int c = 0; c < 4; c++) begin
      chk("idle_srdy", s_tready, 0);
      tick();
    end
    start_frame();
    fill(5, 0, 1);
    drain(1, N + 1, 0, 0);
    s_tvalid = 1'b0;

    // Random frames with random input gaps and random output backpressure.
    for (int t = 0; t < 4; t++) begin
      int b;
      b = $urandom_range(0, PW);
      for (int i = 0; i < N; i++) begin
        pix[i] = (b == 0) ? 0 : $urandom_range(0, (1 << b) - 1);
        usr[i] = $urandom_range(0, 3);
      end
      start_frame();
      fill(-1, 1, 0);
      drain(2, N + 1, 0, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1);
  end

endmodule
